// File: rtl/mnist_argmax_onehot_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
// Shared definitions for the MNIST classifier output path: class count, score
// type, argmax FSM states and the index -> one-hot helper used by every block
// that produces the 7-segment decoder's one-hot digit code.
// -----------------------------------------------------------------------------
package mnist_pkg;

    localparam int SCORE_W   = 16;
    localparam int N_CLASSES = 10;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Indices outside 0..N_CLASSES-1 map to all-zero (blank display).
    function automatic logic [N_CLASSES-1:0] idx_to_onehot(input logic [3:0] idx);
        logic [N_CLASSES-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < N_CLASSES; k++) begin
            if (idx == 4'(k)) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/mnist_argmax_onehot_if.sv
// -----------------------------------------------------------------------------
// mnist_argmax_onehot_if
// Score stream in (valid/ready, signed score, last) and result out
// (valid/ready, one-hot code, binary index, winning score).
//   slave  : the argmax block
//   master : the score source / result consumer
// Optional ARGMAX_MARGIN_EN adds out_margin (unsigned max - second max).
// -----------------------------------------------------------------------------
interface mnist_argmax_onehot_if #(
    parameter int SCORE_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [SCORE_W-1:0] in_score;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [9:0]                out_code;
    logic [3:0]                out_index;
    logic signed [SCORE_W-1:0] out_score;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W:0]          out_margin;
`endif

    modport slave (
        input  in_valid, in_score, in_last, out_ready,
`ifdef ARGMAX_MARGIN_EN
        output out_margin,
`endif
        output in_ready, out_valid, out_code, out_index, out_score
    );

    modport master (
        output in_valid, in_score, in_last, out_ready,
`ifdef ARGMAX_MARGIN_EN
        input  out_margin,
`endif
        input  in_ready, out_valid, out_code, out_index, out_score
    );

endinterface

// File: rtl/mnist_argmax_onehot_cmp.sv
// -----------------------------------------------------------------------------
// argmax_cmp_update
// Combinational compare-and-select of the running max/index against one
// incoming score. Beat 0 loads unconditionally; later beats replace only on a
// strictly greater signed score, so ties keep the lower index.
// With ARGMAX_MARGIN_EN the runner-up score is tracked as well.
// Ports: beat (position in frame), score, cur_* (current), nxt_* (updated).
// -----------------------------------------------------------------------------
module argmax_cmp_update #(
    parameter int SCORE_W = 16
) (
    input  logic [3:0]                beat,
    input  logic signed [SCORE_W-1:0] score,
    input  logic signed [SCORE_W-1:0] cur_max,
    input  logic [3:0]                cur_idx,
`ifdef ARGMAX_MARGIN_EN
    input  logic signed [SCORE_W-1:0] cur_second,
    output logic signed [SCORE_W-1:0] nxt_second,
`endif
    output logic signed [SCORE_W-1:0] nxt_max,
    output logic [3:0]                nxt_idx
);

    logic first;
    assign first = (beat == 4'd0);

    always_comb begin
        nxt_max = cur_max;
        nxt_idx = cur_idx;
        if (first) begin
            nxt_max = score;
            nxt_idx = 4'd0;
        end else if (score > cur_max) begin
            nxt_max = score;
            nxt_idx = beat;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // Runner-up starts at the most negative value; an equal score to the max
    // falls into the second branch, giving second == max (margin 0).
    always_comb begin
        nxt_second = cur_second;
        if (first) begin
            nxt_second = {1'b1, {(SCORE_W-1){1'b0}}};
        end else if (score > cur_max) begin
            nxt_second = cur_max;
        end else if (score > cur_second) begin
            nxt_second = score;
        end
    end
`endif

endmodule

// File: rtl/mnist_argmax_onehot.sv
// -----------------------------------------------------------------------------
// mnist_argmax_onehot
// Streaming argmax over a frame of up to 10 signed class scores (class 0
// first). The frame closes on in_last or on the 10th beat; the result is then
// held (in_ready=0, out_valid=1) until out_ready, after which accumulation
// resumes on the next cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mnist_argmax_onehot_if.slave (score stream in, result out)
// Optional macro ARGMAX_MARGIN_EN: tracks the second max, drives out_margin
// and blanks out_code when the margin is below MIN_MARGIN.
// -----------------------------------------------------------------------------
module mnist_argmax_onehot #(
    parameter int SCORE_W    = 16
`ifdef ARGMAX_MARGIN_EN
   ,parameter int MIN_MARGIN = 0
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mnist_argmax_onehot_if.slave  bus
);
    import mnist_pkg::*;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q;
    logic signed [SCORE_W-1:0] max_q, nxt_max;
    logic [3:0]                idx_q, nxt_idx;
    logic                      accept, closing;

    assign accept  = bus.in_valid && (state_q == ACCUM);
    assign closing = accept && (bus.in_last || (cnt_q == 4'(N_CLASSES-1)));

`ifdef ARGMAX_MARGIN_EN
    logic signed [SCORE_W-1:0] second_q, nxt_second;
    logic                      single_q;
    logic [SCORE_W:0]          margin;
    logic                      confident;
`endif

    argmax_cmp_update #(.SCORE_W(SCORE_W)) u_cmp (
        .beat       (cnt_q),
        .score      (bus.in_score),
        .cur_max    (max_q),
        .cur_idx    (idx_q),
`ifdef ARGMAX_MARGIN_EN
        .cur_second (second_q),
        .nxt_second (nxt_second),
`endif
        .nxt_max    (nxt_max),
        .nxt_idx    (nxt_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            max_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            max_q <= nxt_max;
            idx_q <= nxt_idx;
            cnt_q <= closing ? 4'd0 : cnt_q + 4'd1;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            second_q <= '0;
            single_q <= 1'b0;
        end else if (accept) begin
            second_q <= nxt_second;
            // Only meaningful on the closing beat: frame held a single score.
            single_q <= (cnt_q == 4'd0);
        end
    end

    always_comb begin
        margin = {max_q[SCORE_W-1], max_q} - {second_q[SCORE_W-1], second_q};
        if (single_q) begin
            margin = '1;
        end
        confident = (margin >= (SCORE_W+1)'(MIN_MARGIN));
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_code  = '0;
        bus.out_index = '0;
        bus.out_score = '0;
`ifdef ARGMAX_MARGIN_EN
        bus.out_margin = '0;
`endif
        case (state_q)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (closing) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_code  = idx_to_onehot(idx_q);
                bus.out_index = idx_q;
                bus.out_score = max_q;
`ifdef ARGMAX_MARGIN_EN
                bus.out_margin = margin;
                if (!confident) begin
                    bus.out_code = '0;
                end
`endif
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_mnist_argmax_onehot.sv
// -----------------------------------------------------------------------------
// tb_mnist_argmax_onehot
// Self-checking bench for mnist_argmax_onehot: a constant vector table, a few
// hand-written multi-cycle sequences (backpressure hold, mid-frame reset) and
// randomized frames checked against a plain-arithmetic argmax model.
// -----------------------------------------------------------------------------
module tb_mnist_argmax_onehot;
    import mnist_pkg::*;

    localparam int MARGIN = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mnist_argmax_onehot_if #(.SCORE_W(16)) bus ();

`ifdef ARGMAX_MARGIN_EN
    mnist_argmax_onehot #(.SCORE_W(16), .MIN_MARGIN(MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    mnist_argmax_onehot #(.SCORE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct packed {
        logic [0:9][15:0] sc;
        logic [3:0]       n;
        logic             last;
        logic [3:0]       exp_idx;
        logic [15:0]      exp_score;
        logic [9:0]       exp_code;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: first strict maximum wins; runner-up is the best of the
    // remaining positions; a single-score frame has an all-ones margin.
    function automatic void model(input logic [0:9][15:0] sc, input int n,
                                  output int idx, output int mx, output int margin);
        int second;
        idx = 0;
        mx  = int'($signed(sc[0]));
        for (int i = 1; i < n; i++) begin
            if (int'($signed(sc[i])) > mx) begin
                mx  = int'($signed(sc[i]));
                idx = i;
            end
        end
        second = -(1 << 30);
        for (int i = 0; i < n; i++) begin
            if (i != idx && int'($signed(sc[i])) > second) second = int'($signed(sc[i]));
        end
        margin = (n == 1) ? 131071 : mx - second;
    endfunction

    task automatic do_frame(input logic [0:9][15:0] sc, input int n, input bit use_last,
                            input int exp_i, input int exp_s, input logic [9:0] exp_c_in,
                            input int hold, input bit gaps, input string tag);
        int m_i, m_s, m_m;
        logic [9:0] exp_c;
        model(sc, n, m_i, m_s, m_m);
        exp_c = exp_c_in;
`ifdef ARGMAX_MARGIN_EN
        if (m_m < MARGIN) exp_c = '0;
`endif
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'(($urandom_range(0, 1)));
                @(posedge clk); #1;
            end
            bus.in_valid  = 1'b1;
            bus.in_score  = sc[i];
            bus.in_last   = use_last && (i == n - 1);
            bus.out_ready = gaps ? 1'(($urandom_range(0, 1))) : 1'b0;
            chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
            chk({tag, " out_valid_early"}, 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " out_code"},  32'(bus.out_code),  32'(exp_c));
        chk({tag, " out_index"}, 32'(bus.out_index), 32'(exp_i));
        chk({tag, " out_score"}, 32'(bus.out_score), 32'(16'(exp_s)));
`ifdef ARGMAX_MARGIN_EN
        chk({tag, " out_margin"}, 32'(bus.out_margin), 32'(17'(m_m)));
`endif
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_score = 16'($urandom);
            @(posedge clk); #1;
            chk({tag, " hold in_ready"},  32'(bus.in_ready),  32'd0);
            chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold out_code"},  32'(bus.out_code),  32'(exp_c));
            chk({tag, " hold out_index"}, 32'(bus.out_index), 32'(exp_i));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, " after out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " after out_code"},  32'(bus.out_code),  32'd0);
        chk({tag, " after in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        logic [0:9][15:0] rs;
        int n, ei, es, em;
        bit lst;

        vecs[0] = '{sc: {16'(3), 16'(-1), 16'(7), 16'(2), 16'(0), 16'(5), 16'(7), 16'(1), 16'(-8), 16'(4)},
                    n: 4'd10, last: 1'b1, exp_idx: 4'd2, exp_score: 16'(7), exp_code: 10'b0000000100};
        vecs[1] = '{sc: {16'(-5), 16'(-9), 16'(-2), 16'(-30), 16'(-11), 16'(-4), 16'(-100), 16'(-3), 16'(-8), 16'(-7)},
                    n: 4'd10, last: 1'b0, exp_idx: 4'd2, exp_score: 16'(-2), exp_code: 10'b0000000100};
        vecs[2] = '{sc: {16'(1), 16'(9), 16'(3), 16'(2), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0)},
                    n: 4'd4, last: 1'b1, exp_idx: 4'd1, exp_score: 16'(9), exp_code: 10'b0000000010};
        vecs[3] = '{sc: {16'(0), 16'(1), 16'(2), 16'(3), 16'(4), 16'(5), 16'(6), 16'(7), 16'(8), 16'(20)},
                    n: 4'd10, last: 1'b1, exp_idx: 4'd9, exp_score: 16'(20), exp_code: 10'b1000000000};
        vecs[4] = '{sc: {16'(42), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0)},
                    n: 4'd1, last: 1'b1, exp_idx: 4'd0, exp_score: 16'(42), exp_code: 10'b0000000001};
        vecs[5] = '{sc: {16'(-32768), 16'(-32768), 16'(32767), 16'(-1), 16'(32767), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0)},
                    n: 4'd10, last: 1'b0, exp_idx: 4'd2, exp_score: 16'(32767), exp_code: 10'b0000000100};
        vecs[6] = '{sc: {16'(1), 16'(2), 16'(3), 16'(8), 16'(10), 16'(0), 16'(0), 16'(0), 16'(0), 16'(0)},
                    n: 4'd10, last: 1'b1, exp_idx: 4'd4, exp_score: 16'(10), exp_code: 10'b0000010000};

        bus.in_valid  = 1'b0;
        bus.in_score  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_code",  32'(bus.out_code),  32'd0);
        chk("reset out_index", 32'(bus.out_index), 32'd0);
        chk("reset out_score", 32'(bus.out_score), 32'd0);

        for (int v = 0; v < 7; v++) begin
            do_frame(vecs[v].sc, int'(vecs[v].n), vecs[v].last, int'(vecs[v].exp_idx),
                     int'($signed(vecs[v].exp_score)), vecs[v].exp_code, 0, 1'b0,
                     $sformatf("vec%0d", v));
        end

        // Backpressure: result must hold for 5 cycles with beats offered.
        do_frame(vecs[3].sc, 10, 1'b1, 9, 20, 10'b1000000000, 5, 1'b0, "hold");
        do_frame(vecs[2].sc, 4, 1'b1, 1, 9, 10'b0000000010, 0, 1'b0, "post_hold");

        // Reset after beat 5 of a frame carrying a large score.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_score = 16'(100 + i);
            bus.in_last  = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst out_code",  32'(bus.out_code),  32'd0);
        chk("midrst in_ready",  32'(bus.in_ready),  32'd1);
        do_frame(vecs[3].sc, 10, 1'b0, 9, 20, 10'b1000000000, 0, 1'b0, "after_rst");

        for (int f = 0; f < 60; f++) begin
            n   = $urandom_range(1, 10);
            lst = (n < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            rs  = '0;
            for (int i = 0; i < n; i++) begin
                if (f % 2 == 0) rs[i] = 16'(int'($urandom_range(0, 8)) - 4);
                else            rs[i] = 16'($urandom);
            end
            model(rs, n, ei, es, em);
            do_frame(rs, n, lst, ei, es, idx_to_onehot(4'(ei)), $urandom_range(0, 2), 1'b1,
                     $sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mnist_argmax_onehot.md
Name: mnist_argmax_onehot

Overview:
- Streaming argmax for the MNIST systolic-array classifier output.
- Accepts one signed class score per beat over a valid/ready stream; one frame is 10 scores, class 0 first.
- Emits the winning class as a 10-bit one-hot code, which is the input format of the 7-segment digit decoder, plus the binary index and the winning score.
- Sits between the systolic array's output serializer and the 7-segment display path.

Parameters:
- SCORE_W, 16, width of each signed two's-complement class score.
- N_CLASSES, 10, scores per frame; fixed to 10 for this design, since out_code is 10 bits.
- MIN_MARGIN, 0, minimum (max − second max) for a confident result; used only with ARGMAX_MARGIN_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low, sampled on the rising edge of clk.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a score.
- in_score  in  SCORE_W  signed class score.
- in_last  in  1  marks the final score of a frame (optional early terminator).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_code  out  10  one-hot winning class; bit k set means class k; all-zero means no result.
- out_index  out  4  binary winning class index, 0..9.
- out_score  out  SCORE_W  winning score.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM, beat counter=0, max register cleared.
  - in_ready=1 from the first cycle after reset; out_valid=0, out_code=0, out_index=0, out_score=0.
  - out_code=0 blanks the display.
  - Reset mid-frame discards all partial state with no output.
- State ACCUM: in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - Beat 0 (counter=0) loads max=in_score, idx=0 unconditionally.
  - Beat k>0 replaces max and idx only if in_score > max (signed, strict). Ties keep the lower index.
  - Counter increments per accepted beat.
  - The frame closes on an accepted beat with in_last=1, or on the beat where counter==N_CLASSES-1, whichever comes first.
  - A short frame (in_last before 10 beats) is reported over the scores received.
  - in_last=1 on beat 0 gives a 1-score frame with result index 0.
  - On close: next state is DONE and the counter is cleared. The max/idx update from the closing beat is included.
- State DONE: in_ready=0, out_valid=1, outputs registered and stable.
  - out_code = 1<<idx, out_index=idx, out_score=max.
  - Outputs hold until out_valid && out_ready, then the block returns to ACCUM the next cycle with out_valid=0 and out_code=0.
- Latency: out_valid rises one clk after the closing beat is accepted.
- Throughput: one bubble cycle per frame, because in_ready is 0 during the DONE-to-ACCUM handover.
- Width rules:
  - Comparisons are signed at SCORE_W bits; no extension is needed.
  - The counter is 4 bits and never exceeds 9.
- Beats presented while in_ready=0 are not consumed; the source must hold them.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro ARGMAX_MARGIN_EN.
- When defined:
  - The block also tracks the second-highest score.
  - Adds port out_margin (out, SCORE_W+1, unsigned max − second).
  - If margin < MIN_MARGIN, out_code=0 (display blank) while out_index, out_score and out_valid still report normally.
  - On a 1-score frame, margin saturates to all-ones.
  - On ties, second=max, so margin=0.
- When not defined: no out_margin port, no second-max logic; out_code is always one-hot in DONE.

Decomposition:
- Shared package mnist_pkg holds:
  - N_CLASSES=10 and a score typedef of width SCORE_W (signed).
  - State enum {ACCUM, DONE}.
  - Function idx_to_onehot(4-bit) returning 10-bit, shared with any other producer of the one-hot code.
- One natural sub-module: argmax_cmp_update, a combinational compare-and-select of the current max/idx (and second under the macro) against the incoming score.

Test Plan:
- Reset then frame {3,-1,7,2,0,5,7,1,-8,4} with in_last on beat 9 → out_valid one cycle later; out_code=10'b0000000100, out_index=2, out_score=7 (tie keeps 2).
- All scores negative {-5,-9,-2,-30,...,-7}, -2 at index 2 and the rest lower → out_index=2, out_code=10'b0000000100 (confirms the compare is signed).
- Short frame of 4 beats {1,9,3,2} with in_last on beat 3 → out_index=1, out_code=10'b0000000010; a following 10-beat frame with its max at index 9 → out_code=10'b1000000000.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 → outputs stable, in_ready=0, no beats consumed; then out_ready=1 → ACCUM next cycle, out_code=0.
- Assert rst_n=0 after beat 5 → next cycle out_valid=0, out_code=0, in_ready=1; a fresh frame afterwards is correct.
- With ARGMAX_MARGIN_EN and MIN_MARGIN=3, max=10 at index 4 and second=8 → out_margin=2, out_code=0, out_index=4, out_valid=1.
